// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin table for the dispense controller
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITEM = 2'd1,
        ST_COIN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int COIN_IDX_W = 3;
    localparam int NUM_COINS  = 6;

    // Ordered largest first; coin_sel is an index into this table.
    localparam int COIN_VALUE [NUM_COINS] = '{50, 20, 10, 5, 2, 1};

endpackage

// File: rtl/vend_coin_select.sv
// rtl/vend_coin_select.sv - greedy pick of the largest coin not exceeding the remaining change
module vend_coin_select
    import vend_pkg::*;
#(
    parameter int MONEY_W = 7
) (
    input  logic [MONEY_W-1:0]    change,
    output logic [COIN_IDX_W-1:0] coin_sel,
    output logic [MONEY_W-1:0]    coin_value
);

    logic found;

    // Zero change selects nothing; the controller never presents a coin then.
    always_comb begin
        coin_sel   = '0;
        coin_value = '0;
        found      = 1'b0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (!found && change >= MONEY_W'(COIN_VALUE[i])) begin
                coin_sel   = COIN_IDX_W'(i);
                coin_value = MONEY_W'(COIN_VALUE[i]);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// rtl/vend_dispense_ctrl.sv - delivers accepted purchases as item transfers then change coins
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int TYPE_W  = 3,
    parameter int COUNT_W = 4,
    parameter int MONEY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TYPE_W-1:0]  start_type,
    input  logic [COUNT_W-1:0] start_count,
    input  logic [MONEY_W-1:0] start_change,
    output logic               busy,
    output logic               item_valid,
    output logic [TYPE_W-1:0]  item_type,
    input  logic               item_ready,
    output logic               coin_valid,
    output logic [2:0]         coin_sel,
    input  logic               coin_ready,
    output logic               done,
    output logic               start_err
);

    state_t                  state_q, state_d;
    logic [TYPE_W-1:0]       type_q;
    logic [COUNT_W-1:0]      count_q;
    logic [MONEY_W-1:0]      change_q;
    logic                    start_err_q;
    logic [COIN_IDX_W-1:0]   sel_w;
    logic [MONEY_W-1:0]      denom_w;

    vend_coin_select #(.MONEY_W(MONEY_W)) u_coin_select (
        .change     (change_q),
        .coin_sel   (sel_w),
        .coin_value (denom_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid is a pure function of state, so a transfer is just ready in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            type_q      <= '0;
            count_q     <= '0;
            change_q    <= '0;
            start_err_q <= 1'b0;
        end else begin
            start_err_q <= start && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        type_q   <= start_type;
                        count_q  <= start_count;
                        change_q <= start_change;
                    end
                end
                ST_ITEM: begin
                    if (item_ready) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                ST_COIN: begin
                    if (coin_ready) begin
                        change_q <= change_q - denom_w;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_count != '0) begin
                        state_d = ST_ITEM;
                    end else if (start_change != '0) begin
                        state_d = ST_COIN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ITEM: begin
                if (item_ready && count_q == COUNT_W'(1)) begin
                    state_d = (change_q != '0) ? ST_COIN : ST_DONE;
                end
            end
            ST_COIN: begin
                if (coin_ready && change_q == denom_w) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_ITEM) || (state_q == ST_COIN);
        item_valid = (state_q == ST_ITEM);
        item_type  = (state_q == ST_ITEM) ? type_q : '0;
        coin_valid = (state_q == ST_COIN);
        coin_sel   = (state_q == ST_COIN) ? sel_w : 3'd0;
        done       = (state_q == ST_DONE);
        start_err  = start_err_q;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Output side of the vending machine: once the main controller has accepted a purchase, this block delivers it.
- Delivers the requested items one at a time to the item chute, then pays the change as individual coins to the coin hopper.
- Greedy coin breakdown; each transfer uses a valid/ready handshake.
- Reports busy, completion and rejected requests back to the main controller.

Parameters:
- TYPE_W, 3, width of supply type code
- COUNT_W, 4, width of item count
- MONEY_W, 7, width of change amount (max 127)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request pulse from main controller
- start_type  input  TYPE_W  supply type to dispense
- start_count  input  COUNT_W  number of items
- start_change  input  MONEY_W  change to return
- busy  output  1  high while a request is in progress
- item_valid  output  1  item request to chute
- item_type  output  TYPE_W  type being dispensed
- item_ready  input  1  chute accepts item
- coin_valid  output  1  coin request to hopper
- coin_sel  output  3  denomination index (0=50, 1=20, 2=10, 3=5, 4=2, 5=1)
- coin_ready  input  1  hopper accepts coin
- done  output  1  one-cycle pulse when request is complete
- start_err  output  1  one-cycle pulse when start arrives while busy

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; it overrides everything.
- Reset values: all outputs 0; state IDLE; internal count, change and type registers 0.
- States: IDLE, ITEM, COIN, DONE.
- IDLE:
  - On start, latch type, count and change.
  - Next state: ITEM if count>0; else COIN if change>0; else DONE.
  - busy goes high the cycle after start.
- ITEM:
  - item_valid=1 and item_type=latched type, starting the cycle after the start cycle.
  - A transfer occurs on item_valid & item_ready. Each transfer decrements count.
  - After the last transfer: COIN if change>0, else DONE.
  - item_valid drops in the cycle after the last transfer.
- COIN:
  - coin_sel = largest denomination <= remaining change; coin_valid=1.
  - On coin_valid & coin_ready, subtract that denomination from the remaining change.
  - When the remainder reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
- Handshake rules:
  - valid stays asserted, and type/sel stay stable, until ready is sampled high.
  - valid is never withdrawn without a transfer.
  - item_valid and coin_valid are never high together.
  - ready while valid=0 is ignored.
- Throughput: back-to-back transfers, one per cycle when ready is held high.
- Arithmetic: change subtraction never underflows, since denomination <= remainder by construction. Remainder 0 is never presented as a coin.
- start during busy (any non-IDLE state, including DONE):
  - Request ignored; start_err pulses the next cycle.
  - The current operation continues unchanged.
- Reset mid-transfer: outputs drop the next cycle; no partial state is retained.
- Latency, zero request (count=0, change=0): done pulses in cycle N+1 after start in cycle N.

Decomposition:
- Package vend_pkg holds:
  - state encoding (IDLE/ITEM/COIN/DONE)
  - denomination constant table (50,20,10,5,2,1)
  - coin index width (3)
- Sub-module vend_coin_select: combinational greedy selector.
  - Input: remaining change (MONEY_W).
  - Outputs: coin_sel and the selected denomination value.

Test Plan:
- start type=3, count=2, change=20, ready signals tied high -> item_valid in N+1 and N+2 with item_type=3; coin_sel=1 in N+3; done in N+4.
- start count=0, change=38 -> coin sequence 20,10,5,2,1 (sel 1,2,3,4,5); done after the 5th transfer; no item_valid.
- start count=1, change=127, coin_ready low 3 cycles per coin -> sel 0,0,1,3,4 (127=50+50+20+5+2); valid held and sel stable while stalled.
- start count=0, change=0 in cycle N -> done in N+1; busy never seen high; no valid asserted.
- second start while in ITEM -> start_err pulse; original request completes with unchanged count and change.
- rst asserted while coin_valid=1 -> all outputs 0 next cycle; next start runs a clean full sequence.
